// File: rtl/screen_overlay_ctrl.sv
// Full-screen start / game-over / win overlay: FSM, rectangle hit test for a shared bitmap ROM, frame-locked blink.
// Latency: pixel in cycle N -> offsets/insideRectangle in N+1; ROM answer gated into overlay_dr/overlay_RGB in N+2.
// Backpressure: none; the block follows the pixel stream every cycle and cannot stall it.
module screen_overlay_ctrl #(
    parameter int TOP_LEFT_X      = 192,
    parameter int TOP_LEFT_Y      = 80,
    parameter int OBJECT_WIDTH_X  = 256,
    parameter int OBJECT_HEIGHT_Y = 128,
    parameter int BLINK_FRAMES    = 30,
    parameter int MIN_END_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        gameEnded,
    input  logic        playerWon,
    input  logic        keyStart,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        bitmapDR,
    input  logic [11:0] bitmapRGB,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        insideRectangle,
    output logic [1:0]  screenSel,
    output logic        overlay_dr,
    output logic [11:0] overlay_RGB,
    output logic        gameStartPulse,
    output logic [1:0]  overlayState
);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_END   = 2'd2;

    localparam logic [11:0] X_LO       = 12'(TOP_LEFT_X);
    localparam logic [11:0] X_HI       = 12'(TOP_LEFT_X + OBJECT_WIDTH_X);
    localparam logic [11:0] Y_LO       = 12'(TOP_LEFT_Y);
    localparam logic [11:0] Y_HI       = 12'(TOP_LEFT_Y + OBJECT_HEIGHT_Y);
    localparam logic [10:0] X_OFF      = 11'(TOP_LEFT_X);
    localparam logic [10:0] Y_OFF      = 11'(TOP_LEFT_Y);
    localparam logic [15:0] END_MAX    = 16'(MIN_END_FRAMES);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] end_cnt_q, end_cnt_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        visible_q, visible_d;
    logic        key_q;
    logic        start_pulse_q, start_pulse_d;
    logic        show_q1, show_q2;
    logic [10:0] offset_x_q, offset_x_d;
    logic [10:0] offset_y_q, offset_y_d;
    logic        inside_q, inside_d;
    logic        key_rise, show, in_x, in_y, transition;

    // Bounds are widened to 12 bits so right/bottom edges never wrap.
    always_comb begin
        in_x       = ({1'b0, pixelX} >= X_LO) && ({1'b0, pixelX} < X_HI);
        in_y       = ({1'b0, pixelY} >= Y_LO) && ({1'b0, pixelY} < Y_HI);
        inside_d   = in_x && in_y;
        offset_x_d = inside_d ? (pixelX - X_OFF) : 11'd0;
        offset_y_d = inside_d ? (pixelY - Y_OFF) : 11'd0;
    end

    assign key_rise = keyStart & ~key_q;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        end_cnt_d     = end_cnt_q;
        start_pulse_d = 1'b0;
        case (state_q)
            S_START: begin
                if (key_rise) begin
                    state_d       = S_PLAY;
                    start_pulse_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (gameEnded) begin
                    state_d   = S_END;
                    sel_d     = playerWon ? 2'd2 : 2'd1;
                    end_cnt_d = 16'd0;
                end
            end
            S_END: begin
                if (startOfFrame && (end_cnt_q < END_MAX))
                    end_cnt_d = end_cnt_q + 16'd1;
                if (key_rise && (end_cnt_q == END_MAX)) begin
                    state_d = S_START;
                    sel_d   = 2'd0;
                end
            end
            default: begin
                state_d = S_START;
                sel_d   = 2'd0;
            end
        endcase
        transition = (state_d != state_q);
    end

    // Blink phase only moves on frame boundaries; any state change restarts it visible.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        visible_d   = visible_q;
        if (transition) begin
            blink_cnt_d = 16'd0;
            visible_d   = 1'b1;
        end else if ((BLINK_FRAMES != 0) && startOfFrame) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 16'd0;
                visible_d   = ~visible_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    assign show = (state_q != S_PLAY) && visible_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= S_START;
            sel_q         <= 2'd0;
            end_cnt_q     <= 16'd0;
            blink_cnt_q   <= 16'd0;
            visible_q     <= 1'b1;
            key_q         <= 1'b0;
            start_pulse_q <= 1'b0;
            show_q1       <= 1'b0;
            show_q2       <= 1'b0;
            offset_x_q    <= 11'd0;
            offset_y_q    <= 11'd0;
            inside_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            end_cnt_q     <= end_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            visible_q     <= visible_d;
            key_q         <= keyStart;
            start_pulse_q <= start_pulse_d;
            show_q1       <= show;
            show_q2       <= show_q1;
            offset_x_q    <= offset_x_d;
            offset_y_q    <= offset_y_d;
            inside_q      <= inside_d;
        end
    end

    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign insideRectangle = inside_q;
    assign screenSel       = sel_q;
    assign gameStartPulse  = start_pulse_q;
    assign overlayState    = state_q;
    assign overlay_dr      = bitmapDR & show_q2;
    assign overlay_RGB     = overlay_dr ? bitmapRGB : 12'h000;

endmodule

// File: tb/tb_screen_overlay_ctrl.sv
// Directed bench for screen_overlay_ctrl with a registered bitmap-ROM model driven by insideRectangle.
module tb_screen_overlay_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        gameEnded = 1'b0;
    logic        playerWon = 1'b0;
    logic        keyStart = 1'b0;
    logic [10:0] pixelX = 11'd0;
    logic [10:0] pixelY = 11'd0;
    logic        bitmapDR;
    logic [11:0] bitmapRGB;
    logic [10:0] offsetX, offsetY;
    logic        insideRectangle;
    logic [1:0]  screenSel;
    logic        overlay_dr;
    logic [11:0] overlay_RGB;
    logic        gameStartPulse;
    logic [1:0]  overlayState;

    logic        rom_dr = 1'b0;
    logic [11:0] rom_rgb = 12'h000;
    logic [11:0] rom_color = 12'hF00;

    int checks = 0;
    int failures = 0;

    screen_overlay_ctrl #(.BLINK_FRAMES(2), .MIN_END_FRAMES(60)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .gameEnded(gameEnded), .playerWon(playerWon), .keyStart(keyStart),
        .pixelX(pixelX), .pixelY(pixelY), .bitmapDR(bitmapDR), .bitmapRGB(bitmapRGB),
        .offsetX(offsetX), .offsetY(offsetY), .insideRectangle(insideRectangle),
        .screenSel(screenSel), .overlay_dr(overlay_dr), .overlay_RGB(overlay_RGB),
        .gameStartPulse(gameStartPulse), .overlayState(overlayState)
    );

    always #5 clk = ~clk;

    // One-cycle registered ROM: answers whenever the rectangle was hit last cycle.
    always @(posedge clk) begin
        rom_dr  <= insideRectangle;
        rom_rgb <= insideRectangle ? rom_color : 12'h000;
    end
    assign bitmapDR  = rom_dr;
    assign bitmapRGB = rom_rgb;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_pulse();
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (overlayState !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", overlayState); end
        checks++;
        if (screenSel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", screenSel); end
        checks++;
        if ({offsetX, offsetY} !== 22'd0) begin failures++; $display("FAIL reset_offsets got=%0d,%0d exp=0,0", offsetX, offsetY); end
        checks++;
        if ({insideRectangle, overlay_dr, gameStartPulse} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b%b%b exp=000", insideRectangle, overlay_dr, gameStartPulse);
        end
        checks++;
        if (overlay_RGB !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", overlay_RGB); end
        resetN = 1'b1;
        tick(2);
    endtask

    task automatic test_hit_pipeline();
        rom_color = 12'hF00;
        pixelX = 11'd192;
        pixelY = 11'd80;
        tick(1);
        checks++;
        if (insideRectangle !== 1'b1) begin failures++; $display("FAIL hit_inside got=%b exp=1", insideRectangle); end
        checks++;
        if (offsetX !== 11'd0 || offsetY !== 11'd0) begin failures++; $display("FAIL hit_offsets got=%0d,%0d exp=0,0", offsetX, offsetY); end
        tick(1);
        checks++;
        if (overlay_dr !== 1'b1) begin failures++; $display("FAIL hit_dr got=%b exp=1", overlay_dr); end
        checks++;
        if (overlay_RGB !== 12'hF00) begin failures++; $display("FAIL hit_rgb got=%h exp=F00", overlay_RGB); end
    endtask

    task automatic test_edges();
        logic [10:0] tx [9] = '{11'd447, 11'd448, 11'd191, 11'd300, 11'd300, 11'd300, 11'd2047, 11'd0, 11'd193};
        logic [10:0] ty [9] = '{11'd207, 11'd80, 11'd80, 11'd79, 11'd208, 11'd150, 11'd2047, 11'd0, 11'd81};
        logic        ti [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [10:0] ox [9] = '{11'd255, 11'd0, 11'd0, 11'd0, 11'd0, 11'd108, 11'd0, 11'd0, 11'd1};
        logic [10:0] oy [9] = '{11'd127, 11'd0, 11'd0, 11'd0, 11'd0, 11'd70, 11'd0, 11'd0, 11'd1};
        for (int i = 0; i < 9; i++) begin
            logic [11:0] exp_rgb;
            rom_color = 12'(12'h800 + i);
            exp_rgb = ti[i] ? rom_color : 12'h000;
            pixelX = tx[i];
            pixelY = ty[i];
            tick(1);
            checks++;
            if (insideRectangle !== ti[i] || offsetX !== ox[i] || offsetY !== oy[i]) begin
                failures++;
                $display("FAIL edge_hit[%0d] got=%b/%0d/%0d exp=%b/%0d/%0d", i, insideRectangle, offsetX, offsetY, ti[i], ox[i], oy[i]);
            end
            tick(1);
            checks++;
            if (overlay_dr !== ti[i] || overlay_RGB !== exp_rgb) begin
                failures++;
                $display("FAIL edge_out[%0d] got=%b/%h exp=%b/%h", i, overlay_dr, overlay_RGB, ti[i], exp_rgb);
            end
        end
    endtask

    task automatic test_start_key();
        int pulses = 0;
        rom_color = 12'h0F0;
        pixelX = 11'd300;
        pixelY = 11'd150;
        keyStart = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (gameStartPulse === 1'b1) pulses++;
        end
        keyStart = 1'b0;
        checks++;
        if (pulses !== 1) begin failures++; $display("FAIL start_pulse_count got=%0d exp=1", pulses); end
        checks++;
        if (overlayState !== 2'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", overlayState); end
        tick(3);
        checks++;
        if (overlay_dr !== 1'b0 || overlay_RGB !== 12'h000) begin
            failures++; $display("FAIL play_gated got=%b/%h exp=0/000", overlay_dr, overlay_RGB);
        end
        keyStart = 1'b1;
        tick(1);
        keyStart = 1'b0;
        tick(1);
        checks++;
        if (overlayState !== 2'd1) begin failures++; $display("FAIL play_key_ignored got=%0d exp=1", overlayState); end
    endtask

    task automatic test_end();
        gameEnded = 1'b1;
        playerWon = 1'b1;
        keyStart  = 1'b1;
        tick(1);
        gameEnded = 1'b0;
        keyStart  = 1'b0;
        checks++;
        if (overlayState !== 2'd2 || screenSel !== 2'd2) begin
            failures++; $display("FAIL end_enter got=%0d/%0d exp=2/2", overlayState, screenSel);
        end
        tick(1);
        for (int i = 0; i < 59; i++) frame_pulse();
        keyStart = 1'b1;
        tick(1);
        keyStart = 1'b0;
        checks++;
        if (overlayState !== 2'd2) begin failures++; $display("FAIL end_key_59 got=%0d exp=2", overlayState); end
        gameEnded = 1'b1;
        playerWon = 1'b0;
        tick(1);
        gameEnded = 1'b0;
        checks++;
        if (overlayState !== 2'd2 || screenSel !== 2'd2) begin
            failures++; $display("FAIL end_gameended_ignored got=%0d/%0d exp=2/2", overlayState, screenSel);
        end
        frame_pulse();
        keyStart = 1'b1;
        tick(1);
        keyStart = 1'b0;
        checks++;
        if (overlayState !== 2'd0 || screenSel !== 2'd0) begin
            failures++; $display("FAIL end_key_60 got=%0d/%0d exp=0/0", overlayState, screenSel);
        end
        tick(1);
    endtask

    task automatic test_blink();
        logic exp_on [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rom_color = 12'h00F;
        pixelX = 11'd250;
        pixelY = 11'd100;
        for (int f = 0; f < 5; f++) begin
            tick(3);
            checks++;
            if (overlay_dr !== exp_on[f]) begin failures++; $display("FAIL blink_early[%0d] got=%b exp=%b", f, overlay_dr, exp_on[f]); end
            tick(6);
            checks++;
            if (overlay_dr !== exp_on[f]) begin failures++; $display("FAIL blink_late[%0d] got=%b exp=%b", f, overlay_dr, exp_on[f]); end
            startOfFrame = 1'b1;
            tick(1);
            startOfFrame = 1'b0;
        end
    endtask

    task automatic test_reset_mid_end();
        keyStart = 1'b1;
        tick(1);
        keyStart = 1'b0;
        tick(1);
        gameEnded = 1'b1;
        playerWon = 1'b0;
        tick(1);
        gameEnded = 1'b0;
        checks++;
        if (overlayState !== 2'd2 || screenSel !== 2'd1) begin
            failures++; $display("FAIL gameover_enter got=%0d/%0d exp=2/1", overlayState, screenSel);
        end
        frame_pulse();
        frame_pulse();
        tick(3);
        checks++;
        if (overlay_dr !== 1'b0) begin failures++; $display("FAIL end_blink_off got=%b exp=0", overlay_dr); end
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if ({overlayState, screenSel, offsetX, offsetY, insideRectangle, overlay_dr, overlay_RGB, gameStartPulse} !== 40'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%0d/%0d/%0d/%0d/%b/%b/%h/%b exp=all zero", overlayState, screenSel,
                     offsetX, offsetY, insideRectangle, overlay_dr, overlay_RGB, gameStartPulse);
        end
        tick(1);
        resetN = 1'b1;
        tick(1);
        checks++;
        if (overlayState !== 2'd0) begin failures++; $display("FAIL midreset_state got=%0d exp=0", overlayState); end
        tick(2);
        checks++;
        if (overlay_dr !== 1'b1 || overlay_RGB !== rom_color) begin
            failures++; $display("FAIL midreset_visible got=%b/%h exp=1/%h", overlay_dr, overlay_RGB, rom_color);
        end
    endtask

    initial begin
        test_reset();
        test_hit_pipeline();
        test_edges();
        test_start_key();
        test_end();
        test_blink();
        test_reset_mid_end();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/screen_overlay_ctrl.md
Name: screen_overlay_ctrl

Overview:
- Full-screen overlay controller for the Digger display path.
- Sequences the start, game-over and win screens with an FSM driven by the game and keyboard.
- Computes the rectangle hit and offsets for one shared external multi-screen bitmap ROM, and selects which screen that ROM shows.
- Adds frame-synchronous blinking, then gates the ROM output into one drawing request and RGB pair for the top-level mux.

Parameters:
- TOP_LEFT_X, 192, overlay rectangle left edge (pixels).
- TOP_LEFT_Y, 80, overlay rectangle top edge (pixels).
- OBJECT_WIDTH_X, 256, rectangle width.
- OBJECT_HEIGHT_Y, 128, rectangle height.
- BLINK_FRAMES, 30, frames per blink half-period; 0 = solid (no blink).
- MIN_END_FRAMES, 60, frames the end screen ignores keyStart.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- gameEnded  in  1  level/pulse, game finished
- playerWon  in  1  sampled with gameEnded: 1 = win screen, 0 = game-over screen
- keyStart  in  1  start key level (debounced upstream)
- pixelX  in  11  current pixel X
- pixelY  in  11  current pixel Y
- bitmapDR  in  1  ROM drawing request (1-cycle registered ROM)
- bitmapRGB  in  12  ROM pixel colour
- offsetX  out  11  pixelX - TOP_LEFT_X, registered
- offsetY  out  11  pixelY - TOP_LEFT_Y, registered
- insideRectangle  out  1  registered rectangle hit to ROM
- screenSel  out  2  0 = start, 1 = game over, 2 = win; 3 is never driven
- overlay_dr  out  1  final drawing request
- overlay_RGB  out  12  final colour
- gameStartPulse  out  1  one-cycle pulse when play begins
- overlayState  out  2  FSM state, for debug and the top-level mux

Behaviour:
- Reset (async, resetN=0):
  - state=S_START, screenSel=0, offsets=0, insideRectangle=0.
  - overlay_dr=0, overlay_RGB=0, gameStartPulse=0.
  - frame counters=0, visible=1, key edge register=0.
  - Reset mid-operation from any state returns here on the next clock after release.
- Hit test:
  - Condition: TOP_LEFT_X <= pixelX < TOP_LEFT_X+OBJECT_WIDTH_X and TOP_LEFT_Y <= pixelY < TOP_LEFT_Y+OBJECT_HEIGHT_Y.
  - Bounds are compared in 12 bits so the sum never wraps.
  - Offsets are 11-bit unsigned differences. Outside the rectangle, offsets are forced to 0.
- Pixel pipeline:
  - Pixel presented in cycle N produces offsets, insideRectangle and screenSel in cycle N+1.
  - The ROM answers in N+2.
  - In N+2: overlay_dr = bitmapDR & show_q2; overlay_RGB = bitmapRGB when overlay_dr, else 12'h000.
  - overlay_dr and overlay_RGB are combinational from the ROM inputs and show_q2.
  - show = (state != S_PLAY) & visible. It is delayed 2 stages (show_q1, show_q2) to align with the ROM.
  - screenSel is registered with the offsets.
- Key edge: keyRise = keyStart & ~keyStart_d. Only rising edges act; holding the key does nothing further.
- FSM (states encoded 0/1/2):
  - S_START: on keyRise -> S_PLAY, with gameStartPulse=1 for exactly that cycle.
  - S_PLAY:
    - On gameEnded -> S_END; latch screenSel = playerWon ? 2 : 1; clear endCnt.
    - gameEnded takes priority over a simultaneous keyRise. keyRise in S_PLAY is ignored.
  - S_END:
    - endCnt increments on each startOfFrame and saturates at MIN_END_FRAMES.
    - keyRise with endCnt < MIN_END_FRAMES is ignored.
    - keyRise with endCnt == MIN_END_FRAMES -> S_START, screenSel=0.
    - gameEnded in S_END is ignored.
- Blink:
  - blinkCnt advances only on startOfFrame, so visibility never changes mid-frame.
  - When blinkCnt reaches BLINK_FRAMES-1 it wraps to 0 and visible toggles.
  - Every state transition resets blinkCnt=0 and visible=1.
  - With BLINK_FRAMES=0: visible stays 1 and the counter is idle.
- In S_PLAY: overlay_dr=0 regardless of ROM inputs, after the 2-cycle pipeline drains.

Test Plan:
- Reset then pixel (192,80), bitmapDR=1, bitmapRGB=12'hF00: insideRectangle=1 and offsets (0,0) one cycle later; overlay_dr=1 and overlay_RGB=12'hF00 two cycles later.
- Edge pixels (447,207) -> inside, offsets (255,127); (448,80) and (191,80) -> insideRectangle=0, offsets 0, overlay_dr=0.
- In S_START: keyStart held 10 cycles -> exactly one gameStartPulse and state=1; further pixels give overlay_dr=0 even with bitmapDR=1.
- In S_PLAY, gameEnded=1, playerWon=1 and keyRise in the same cycle -> state=2, screenSel=2; keyRise after 59 startOfFrame pulses is ignored; keyRise after 60 -> state=0, screenSel=0.
- BLINK_FRAMES=2 in S_START: overlay_dr pattern per frame is on, on, off, off, on. A toggle never occurs between two startOfFrame pulses.
- Assert resetN=0 mid-frame in S_END -> all outputs 0 immediately; state=0 and visible=1 after release.
